param_set_assoc_cache: RTL and testbench

Read-only, parametrised N-way set-associative cache. It replaces the single-way, handshake-free lookup with a request/response handshake and a line refill from backing memory over a ready/valid burst interface. It adds valid bits, flush, per-set victim selection and hit/miss counters. It sits between the load requester and the main-memory model.

---
 rtl/cache_pkg.sv | 31 +++
 rtl/param_set_assoc_cache_if.sv | 28 ++
 rtl/cache_set_store.sv | 59 +++++
 rtl/param_set_assoc_cache.sv | 177 +++++++++++++++++
 tb/tb_param_set_assoc_cache.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared types and address-split helpers for the set-associative cache.
package cache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL_REQ,
        S_REFILL_DATA,
        S_RESPOND
    } state_e;

    function automatic int unsigned off_w(input int unsigned words_per_line);
        return 32'($clog2(words_per_line)) + 32'd2;
    endfunction

    function automatic int unsigned idx_w(input int unsigned num_sets);
        return 32'($clog2(num_sets));
    endfunction

    function automatic int unsigned tag_w(input int unsigned addr_w,
                                          input int unsigned words_per_line,
                                          input int unsigned num_sets);
        return addr_w - idx_w(num_sets) - off_w(words_per_line);
    endfunction

    // Clears the byte/word offset bits so the address points at the line start.
    function automatic logic [63:0] line_align(input logic [63:0] addr, input int unsigned offw);
        return addr & ~((64'd1 << offw) - 64'd1);
    endfunction

endpackage

// File: rtl/param_set_assoc_cache_if.sv
// Requester and backing-memory handshake bundle of the cache.
interface param_set_assoc_cache_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              flush;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              resp_hit;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;

    modport master (
        output req_valid, req_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
        input  req_ready, resp_valid, resp_data, resp_hit, mem_req_valid, mem_req_addr
    );

    modport slave (
        input  req_valid, req_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
        output req_ready, resp_valid, resp_data, resp_hit, mem_req_valid, mem_req_addr
    );
endinterface

// File: rtl/cache_set_store.sv
// Per-set tag/valid storage with round-robin victim pointers; all ports act on set idx_i.
module cache_set_store #(
    parameter int unsigned NUM_SETS = 256,
    parameter int unsigned WAYS     = 2,
    parameter int unsigned TAG_W    = 18,
    parameter int unsigned IDX_W    = 8,
    parameter int unsigned WAY_W    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic [WAYS-1:0]  hit_vec_o,
    output logic [WAY_W-1:0] victim_o,
    input  logic             clr_en_i,
    input  logic [WAY_W-1:0] clr_way_i,
    input  logic             wr_en_i,
    input  logic [WAY_W-1:0] wr_way_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic             flush_i
);
    logic [TAG_W-1:0]                  tag_q [NUM_SETS][WAYS];
    logic [NUM_SETS-1:0][WAYS-1:0]     valid_q;
    logic [NUM_SETS-1:0][WAY_W-1:0]    ptr_q;
    logic                              found;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            ptr_q   <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else begin
            if (clr_en_i) valid_q[idx_i][clr_way_i] <= 1'b0;
            if (wr_en_i) begin
                valid_q[idx_i][wr_way_i] <= 1'b1;
                ptr_q[idx_i] <= (ptr_q[idx_i] == WAY_W'(WAYS - 1)) ? '0 : ptr_q[idx_i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) tag_q[idx_i][wr_way_i] <= wr_tag_i;
    end

    // Lowest invalid way wins; otherwise fall back to the round-robin pointer.
    always_comb begin
        hit_vec_o = '0;
        victim_o  = ptr_q[idx_i];
        found     = 1'b0;
        for (int w = 0; w < int'(WAYS); w++) begin
            hit_vec_o[w] = valid_q[idx_i][w] && (tag_q[idx_i][w] == tag_i);
            if (!found && !valid_q[idx_i][w]) begin
                victim_o = WAY_W'(w);
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/param_set_assoc_cache.sv
// Read-only N-way set-associative cache with burst refill, flush and saturating hit/miss counters.
module param_set_assoc_cache
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned WORDS_PER_LINE = 16,
    parameter int unsigned NUM_SETS       = 256,
    parameter int unsigned WAYS           = 2,
    parameter int unsigned COUNT_W        = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    param_set_assoc_cache_if.slave      bus,
    output logic [COUNT_W-1:0]          hit_count,
    output logic [COUNT_W-1:0]          miss_count
);
    localparam int unsigned OFF_W  = off_w(WORDS_PER_LINE);
    localparam int unsigned IDX_W  = idx_w(NUM_SETS);
    localparam int unsigned TAG_W  = tag_w(ADDR_W, WORDS_PER_LINE, NUM_SETS);
    localparam int unsigned WOFF_W = $clog2(WORDS_PER_LINE);
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned DEPTH  = WAYS * NUM_SETS * WORDS_PER_LINE;
    localparam int unsigned DA_W   = $clog2(DEPTH);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WAY_W-1:0]    victim_q, victim_d;
    logic [WOFF_W-1:0]   beat_q, beat_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_hit_q, resp_hit_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;
    logic                mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_W-1:0]   mem_req_addr_q, mem_req_addr_d;
    logic [COUNT_W-1:0]  hit_q, hit_d, miss_q, miss_d;

    logic [DATA_W-1:0]   data_q [DEPTH];
    logic [WAYS-1:0]     hit_vec;
    logic [WAY_W-1:0]    victim_way, hit_way;
    logic                clr_en, wr_en, flush_all, data_we;

    wire [TAG_W-1:0]  tag_cur  = addr_q[ADDR_W-1 -: TAG_W];
    wire [IDX_W-1:0]  idx_cur  = addr_q[OFF_W +: IDX_W];
    wire [WOFF_W-1:0] word_cur = addr_q[2 +: WOFF_W];

    function automatic logic [DA_W-1:0] da_index(input logic [WAY_W-1:0] way,
                                                 input logic [IDX_W-1:0] idx,
                                                 input logic [WOFF_W-1:0] word);
        return DA_W'(way) * DA_W'(NUM_SETS * WORDS_PER_LINE)
             + DA_W'(idx) * DA_W'(WORDS_PER_LINE) + DA_W'(word);
    endfunction

    cache_set_store #(
        .NUM_SETS(NUM_SETS), .WAYS(WAYS), .TAG_W(TAG_W), .IDX_W(IDX_W), .WAY_W(WAY_W)
    ) u_store (
        .clk(clk), .rst(rst), .idx_i(idx_cur), .tag_i(tag_cur),
        .hit_vec_o(hit_vec), .victim_o(victim_way),
        .clr_en_i(clr_en), .clr_way_i(victim_q),
        .wr_en_i(wr_en), .wr_way_i(victim_q), .wr_tag_i(tag_cur),
        .flush_i(flush_all)
    );

    always_comb begin
        hit_way = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (hit_vec[w]) hit_way = WAY_W'(w);
        end
    end

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        victim_d        = victim_q;
        beat_d          = beat_q;
        resp_valid_d    = 1'b0;
        resp_hit_d      = resp_hit_q;
        resp_data_d     = resp_data_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_addr_d  = mem_req_addr_q;
        hit_d           = hit_q;
        miss_d          = miss_q;
        clr_en          = 1'b0;
        wr_en           = 1'b0;
        flush_all       = 1'b0;
        data_we         = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.flush) begin
                    flush_all = 1'b1;
                end else if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (|hit_vec) begin
                    resp_data_d  = data_q[da_index(hit_way, idx_cur, word_cur)];
                    resp_hit_d   = 1'b1;
                    resp_valid_d = 1'b1;
                    if (hit_q != '1) hit_d = hit_q + 1'b1;
                    state_d = S_RESPOND;
                end else begin
                    if (miss_q != '1) miss_d = miss_q + 1'b1;
                    victim_d        = victim_way;
                    beat_d          = '0;
                    mem_req_valid_d = 1'b1;
                    mem_req_addr_d  = ADDR_W'(line_align(64'(addr_q), OFF_W));
                    state_d         = S_REFILL_REQ;
                end
            end
            S_REFILL_REQ: begin
                // The old line goes invalid as soon as memory commits to the fetch.
                if (bus.mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    clr_en          = 1'b1;
                    state_d         = S_REFILL_DATA;
                end
            end
            S_REFILL_DATA: begin
                if (bus.mem_resp_valid) begin
                    data_we = 1'b1;
                    beat_d  = beat_q + 1'b1;
                    if (beat_q == word_cur) resp_data_d = bus.mem_resp_data;
                    if (beat_q == WOFF_W'(WORDS_PER_LINE - 1)) begin
                        wr_en        = 1'b1;
                        resp_hit_d   = 1'b0;
                        resp_valid_d = 1'b1;
                        state_d      = S_RESPOND;
                    end
                end
            end
            S_RESPOND: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            victim_q        <= '0;
            beat_q          <= '0;
            resp_valid_q    <= 1'b0;
            resp_hit_q      <= 1'b0;
            resp_data_q     <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            hit_q           <= '0;
            miss_q          <= '0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            victim_q        <= victim_d;
            beat_q          <= beat_d;
            resp_valid_q    <= resp_valid_d;
            resp_hit_q      <= resp_hit_d;
            resp_data_q     <= resp_data_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
            hit_q           <= hit_d;
            miss_q          <= miss_d;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) data_q[da_index(victim_q, idx_cur, beat_q)] <= bus.mem_resp_data;
    end

    assign bus.req_ready     = (state_q == S_IDLE) && !bus.flush;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_hit      = resp_hit_q;
    assign bus.resp_data     = resp_data_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_addr  = mem_req_addr_q;
    assign hit_count         = hit_q;
    assign miss_count        = miss_q;
endmodule

// File: tb/tb_param_set_assoc_cache.sv
// Directed bench for param_set_assoc_cache; the memory model returns each word's own byte address.
module tb_param_set_assoc_cache;
    localparam int unsigned CW   = 4;
    localparam int          CMAX = 15;

    logic clk = 1'b0;
    logic rst;
    logic [CW-1:0] hit_count, miss_count;
    int n_checks = 0;
    int n_fail   = 0;
    int exp_hits = 0;
    int exp_miss = 0;

    always #5 clk = ~clk;

    param_set_assoc_cache_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    param_set_assoc_cache #(
        .ADDR_W(32), .DATA_W(32), .WORDS_PER_LINE(16), .NUM_SETS(256), .WAYS(2), .COUNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .hit_count(hit_count), .miss_count(miss_count)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < CMAX) ? v + 1 : CMAX;
    endfunction

    task automatic idle_inputs();
        bus.req_valid      = 1'b0;
        bus.req_addr       = '0;
        bus.flush          = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        rst      = 1'b0;
        exp_hits = 0;
        exp_miss = 0;
    endtask

    // Issues one read and plays the memory side; abort_beat >= 0 asserts rst during that beat.
    task automatic do_read(input logic [31:0] addr, input bit exp_hit, input int rdy_dly,
                           input int gap, input int abort_beat);
        logic [31:0] line, word;
        int  n;
        bit  stable, extra_req;
        line = addr & 32'hFFFF_FFC0;
        word = addr & 32'hFFFF_FFFC;
        n = 0;
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("req_ready_before", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        check_eq("resp_valid_lookup", 64'(bus.resp_valid), 64'd0);
        if (exp_hit) begin
            @(negedge clk);
            exp_hits = sat_inc(exp_hits);
            check_eq("hit_resp_valid", 64'(bus.resp_valid), 64'd1);
            check_eq("hit_resp_hit", 64'(bus.resp_hit), 64'd1);
        end else begin
            @(negedge clk);
            check_eq("mem_req_valid", 64'(bus.mem_req_valid), 64'd1);
            check_eq("mem_req_addr", 64'(bus.mem_req_addr), 64'(line));
            stable = 1'b1;
            repeat (rdy_dly) begin
                @(negedge clk);
                if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== line) stable = 1'b0;
            end
            if (rdy_dly > 0) check_eq("mem_req_stable", 64'(stable), 64'd1);
            bus.mem_req_ready = 1'b1;
            @(negedge clk);
            bus.mem_req_ready = 1'b0;
            check_eq("mem_req_dropped", 64'(bus.mem_req_valid), 64'd0);
            extra_req = 1'b0;
            for (int k = 0; k < 16; k++) begin
                repeat (gap) begin
                    @(negedge clk);
                    if (bus.mem_req_valid !== 1'b0) extra_req = 1'b1;
                end
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_data  = line + 32'(4 * k);
                if (k == abort_beat) rst = 1'b1;
                @(negedge clk);
                bus.mem_resp_valid = 1'b0;
                if (k == abort_beat) begin
                    rst      = 1'b0;
                    exp_hits = 0;
                    exp_miss = 0;
                    check_eq("abort_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
                    check_eq("abort_req_ready", 64'(bus.req_ready), 64'd1);
                    check_eq("abort_hit_count", 64'(hit_count), 64'd0);
                    check_eq("abort_miss_count", 64'(miss_count), 64'd0);
                    return;
                end
                if (k < 15 && bus.mem_req_valid !== 1'b0) extra_req = 1'b1;
            end
            check_eq("single_fetch", 64'(extra_req), 64'd0);
            exp_miss = sat_inc(exp_miss);
            check_eq("miss_resp_valid", 64'(bus.resp_valid), 64'd1);
            check_eq("miss_resp_hit", 64'(bus.resp_hit), 64'd0);
        end
        check_eq("resp_data", 64'(bus.resp_data), 64'(word));
        check_eq("hit_count", 64'(hit_count), 64'(exp_hits));
        check_eq("miss_count", 64'(miss_count), 64'(exp_miss));
        @(negedge clk);
        check_eq("resp_pulse_end", 64'(bus.resp_valid), 64'd0);
        check_eq("req_ready_after", 64'(bus.req_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        do_reset();
        check_eq("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check_eq("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check_eq("rst_resp_hit", 64'(bus.resp_hit), 64'd0);
        check_eq("rst_resp_data", 64'(bus.resp_data), 64'd0);
        check_eq("rst_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
        check_eq("rst_mem_req_addr", 64'(bus.mem_req_addr), 64'd0);
        check_eq("rst_counts", 64'({hit_count, miss_count}), 64'd0);

        // cold miss then hit in the same line
        do_read(32'h0000_1004, 1'b0, 0, 0, -1);
        do_read(32'h0000_1008, 1'b1, 0, 0, -1);

        // three lines mapping to set 0x40 in a 2-way cache
        do_reset();
        do_read(32'h0000_1000, 1'b0, 0, 0, -1);
        do_read(32'h0000_5000, 1'b0, 0, 0, -1);
        do_read(32'h0000_9000, 1'b0, 0, 0, -1);
        do_read(32'h0000_5000, 1'b1, 0, 0, -1);
        do_read(32'h0000_1000, 1'b0, 0, 0, -1);
        check_eq("conflict_hits", 64'(hit_count), 64'd1);
        check_eq("conflict_misses", 64'(miss_count), 64'd4);
        do_read(32'h0000_9004, 1'b1, 0, 0, -1);

        // flush wins over a simultaneous request and invalidates everything
        do_reset();
        do_read(32'h0000_1000, 1'b0, 0, 0, -1);
        do_read(32'h0000_1004, 1'b1, 0, 0, -1);
        bus.flush     = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_1000;
        #1;
        check_eq("flush_req_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        check_eq("flush_stays_idle", 64'(bus.req_ready), 64'd1);
        do_read(32'h0000_1000, 1'b0, 0, 0, -1);

        // memory backpressure and gapped beats
        do_reset();
        do_read(32'h0000_3008, 1'b0, 5, 2, -1);
        do_read(32'h0000_303C, 1'b1, 0, 0, -1);

        // reset during beat 7, stray beats in IDLE, then a clean refill
        do_reset();
        do_read(32'h0000_2000, 1'b0, 0, 0, 7);
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        check_eq("stray_beats_idle", 64'({bus.req_ready, bus.mem_req_valid, bus.resp_valid}), 64'b100);
        do_read(32'h0000_2000, 1'b0, 0, 0, -1);
        do_read(32'h0000_2004, 1'b1, 0, 0, -1);

        // miss counter saturates at 15
        do_reset();
        for (int i = 0; i < 20; i++) begin
            do_read(32'h0004_0000 + 32'(i) * 32'h40, 1'b0, 0, 0, -1);
        end
        check_eq("sat_miss_count", 64'(miss_count), 64'd15);
        check_eq("sat_hit_count", 64'(hit_count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
